apb_cmd_arbiter: RTL and testbench

APB_CMD_ARBITER -- requirements
Module: apb_cmd_arbiter

---
 rtl/apb_pkg.sv | 28 ++
 rtl/apb_rr_pick.sv | 32 +++
 rtl/apb_cmd_arbiter.sv | 135 +++++++++++++
 tb/tb_apb_cmd_arbiter.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared encodings for the APB command arbiter.
// Transfer codes, FSM states and a one-hot helper.
package apb_pkg;

  typedef enum logic [1:0] {
    NO_TRANSFER = 2'b00,
    WRITE_XFER  = 2'b01,
    READ_XFER   = 2'b10
  } xfer_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACTIVE = 2'b01,
    ST_RESP   = 2'b10
  } state_e;

  function automatic logic [1:0] oh_to_idx(
    input logic [3:0] oh
  );
    logic [1:0] idx;
    idx = '0;
    for (int i = 0; i < 4; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/apb_rr_pick.sv
// Round-robin picker: search starts one past the last grant.
// Pure combinational, one-hot grant output.
module apb_rr_pick
  import apb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         last_grant,
  output logic [NUM_REQ-1:0] grant
);

  localparam int IW = (NUM_REQ > 2) ? 2 : 1;

  logic [IW-1:0] w_idx;
  logic          w_found;

  always_comb begin
    grant   = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = IW'((32'(last_grant) + 32'(k))
                  % 32'(NUM_REQ));
      if (!w_found && req[w_idx]) begin
        grant[w_idx] = 1'b1;
        w_found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_cmd_arbiter.sv
// Shares one APB master between NUM_REQ requesters.
// One command in flight: IDLE -> ACTIVE -> RESP -> IDLE.
module apb_cmd_arbiter
  import apb_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          PCLK,
  input  logic                          PRESETn,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          rsp_err,
  output logic [1:0]                    m_transfer,
  output logic [ADDR_WIDTH-1:0]         m_address,
  output logic [DATA_WIDTH-1:0]         m_write_data,
  input  logic                          apb_penable,
  input  logic                          apb_pready,
  input  logic                          apb_pslverr,
  input  logic                          apb_pparerr,
  input  logic [DATA_WIDTH-1:0]         apb_prdata,
  output logic                          busy,
  output logic [1:0]                    grant_id
);

  state_e                  r_state;
  state_e                  w_next;
  logic [1:0]              r_last;
  logic [1:0]              r_owner;
  logic                    r_write;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic                    r_err;

  logic [NUM_REQ-1:0]      w_grant;
  logic [1:0]              w_idx;
  logic                    w_accept;
  logic                    w_done;
  logic                    w_sel_write;
  logic [ADDR_WIDTH-1:0]   w_sel_addr;
  logic [DATA_WIDTH-1:0]   w_sel_wdata;

  apb_rr_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_pick (
    .req       (req_valid),
    .last_grant(r_last),
    .grant     (w_grant)
  );

  assign w_idx = oh_to_idx(4'(w_grant));

  always_comb begin
    w_sel_write = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_sel_write = req_write[i];
        w_sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_done   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (|req_valid) begin
          w_accept = 1'b1;
          w_next   = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (apb_penable && apb_pready) begin
          w_done = 1'b1;
          w_next = ST_RESP;
        end
      end
      ST_RESP: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state <= ST_IDLE;
      r_last  <= 2'(NUM_REQ - 1);
      r_owner <= '0;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_last  <= w_idx;
        r_owner <= w_idx;
        r_write <= w_sel_write;
        r_addr  <= w_sel_addr;
        r_wdata <= w_sel_wdata;
      end
      if (w_done) begin
        r_err   <= apb_pslverr | apb_pparerr;
        r_rdata <= r_write ? '0 : apb_prdata;
      end
    end
  end

  // Reset gating keeps the combinational accept silent while held in reset.
  assign req_ready = (w_accept && PRESETn) ? w_grant : '0;
  assign rsp_valid = (r_state == ST_RESP)
                   ? (NUM_REQ'(1'b1) << r_owner) : '0;

  assign m_transfer   = (r_state != ST_ACTIVE) ? NO_TRANSFER
                      : (r_write ? WRITE_XFER : READ_XFER);
  assign m_address    = r_addr;
  assign m_write_data = r_wdata;
  assign rsp_rdata    = r_rdata;
  assign rsp_err      = r_err;
  assign busy         = (r_state != ST_IDLE);
  assign grant_id     = r_owner;

endmodule

// File: tb/tb_apb_cmd_arbiter.sv
// Scoreboard bench for apb_cmd_arbiter with a behavioural
// round-robin model and a fixed-latency APB slave.
module tb_apb_cmd_arbiter;

  localparam int NR = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            PCLK = 1'b0;
  logic            PRESETn;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_write;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [NR-1:0]   req_ready;
  logic [NR-1:0]   rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err;
  logic [1:0]      m_transfer;
  logic [AW-1:0]   m_address;
  logic [DW-1:0]   m_write_data;
  logic            apb_penable;
  logic            apb_pready;
  logic            apb_pslverr;
  logic            apb_pparerr;
  logic [DW-1:0]   apb_prdata;
  logic            busy;
  logic [1:0]      grant_id;

  apb_cmd_arbiter #(
    .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .m_transfer(m_transfer), .m_address(m_address),
    .m_write_data(m_write_data),
    .apb_penable(apb_penable), .apb_pready(apb_pready),
    .apb_pslverr(apb_pslverr), .apb_pparerr(apb_pparerr),
    .apb_prdata(apb_prdata),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 PCLK = ~PCLK;

  int cyc = 0;
  always @(posedge PCLK) cyc++;

  typedef struct {
    int          owner;
    logic        wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic        err;
    int          acc;
    int          due;
  } exp_t;

  typedef struct {
    int            w;
    logic [DW-1:0] rdata;
    logic          err;
    logic          par;
  } slv_t;

  exp_t sb[$];
  slv_t sq[$];
  int   wins[$];
  int   n_pass = 0;
  int   n_tot  = 0;

  int            m_last;
  int            m_gid;
  int            idle_at;
  int            nx_w;
  logic [DW-1:0] nx_rdata;
  logic          nx_err;
  logic          nx_par;
  bit            rnd = 0;
  bit            rnd_params = 0;
  bit            hold_all = 0;

  task automatic chk(string nm, bit ok,
                     logic [63:0] act, logic [63:0] exp);
    n_tot++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t",
                  nm, act, exp, $time);
  endtask

  function automatic bit outs_zero();
    return req_ready == '0 && rsp_valid == '0 &&
           rsp_rdata == '0 && !rsp_err &&
           m_transfer == 2'b00 && m_address == '0 &&
           m_write_data == '0 && !busy &&
           grant_id == 2'b00;
  endfunction

  function automatic int pick(logic [NR-1:0] v, int last);
    for (int k = 1; k <= NR; k++) begin
      if (v[(last + k) % NR]) return (last + k) % NR;
    end
    return -1;
  endfunction

  task automatic rand_nx();
    nx_w     = $urandom_range(0, 3);
    nx_rdata = $urandom;
    nx_err   = ($urandom_range(0, 4) == 0);
    nx_par   = 1'($urandom);
  endtask

  task automatic new_req(int i);
    req_valid[i] = 1'b1;
    req_write[i] = 1'($urandom);
    req_addr[i*AW +: AW]  = $urandom;
    req_wdata[i*DW +: DW] = $urandom;
  endtask

  task automatic model_reset();
    m_last  = NR - 1;
    m_gid   = 0;
    idle_at = 0;
  endtask

  // One cycle: sample at negedge, drive just after posedge.
  task automatic step();
    int w;
    int a;
    logic [NR-1:0] er;
    exp_t e;
    slv_t s;
    @(negedge PCLK);
    w  = (cyc >= idle_at) ? pick(req_valid, m_last) : -1;
    er = '0;
    if (w >= 0) er[w] = 1'b1;
    chk("req_ready", req_ready == er,
        64'(req_ready), 64'(er));
    chk("busy", busy == (cyc < idle_at),
        64'(busy), 64'(cyc < idle_at));
    chk("grant_id", grant_id == 2'(m_gid),
        64'(grant_id), 64'(m_gid));
    if (w >= 0) begin
      a = -1;
      for (int i = 0; i < NR; i++) if (req_ready[i]) a = i;
      wins.push_back(a);
      e.owner = w;
      e.wr    = req_write[w];
      e.addr  = req_addr[w*AW +: AW];
      e.wdata = req_wdata[w*DW +: DW];
      e.rdata = e.wr ? '0 : nx_rdata;
      e.err   = nx_err;
      e.acc   = cyc;
      e.due   = cyc + 4 + nx_w;
      sb.push_back(e);
      s.w     = nx_w;
      s.rdata = nx_rdata;
      s.err   = nx_err;
      s.par   = nx_par;
      sq.push_back(s);
      m_last  = w;
      m_gid   = w;
      idle_at = cyc + 5 + nx_w;
      if (rnd_params) rand_nx();
    end
    @(posedge PCLK);
    #1;
    if (w >= 0) begin
      req_valid[w] = 1'b0;
      if (hold_all) new_req(w);
    end
    if (rnd) begin
      for (int i = 0; i < NR; i++) begin
        if (!req_valid[i]) begin
          if ($urandom_range(0, 3) == 0) new_req(i);
        end else if ($urandom_range(0, 15) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      if (sb.size() == 0 && req_valid == '0 &&
          cyc >= idle_at) return;
      step();
    end
    chk("drain_timeout", 1'b0, 64'(sb.size()), 64'd0);
  endtask

  task automatic run_until(int n);
    for (int i = 0; i < 200; i++) begin
      if (wins.size() >= n) return;
      step();
    end
    chk("accept_timeout", 1'b0, 64'(wins.size()), 64'(n));
  endtask

  task automatic do_reset(int n);
    PRESETn = 1'b0;
    #1;
    chk("reset_immediate", outs_zero(),
        {32'(m_transfer), 32'(rsp_valid)}, 64'd0);
    repeat (n) @(negedge PCLK);
    @(posedge PCLK);
    #1;
    PRESETn = 1'b1;
    model_reset();
  endtask

  // Monitor: pops the scoreboard on every response pulse.
  exp_t          mon_e;
  logic [NR-1:0] mon_v;
  logic [DW-1:0] mon_rd = '0;
  logic          mon_er = 1'b0;

  initial begin
    forever begin
      @(negedge PCLK);
      if (!PRESETn) begin
        chk("reset_outputs", outs_zero(),
            {rsp_rdata, m_address}, 64'd0);
        sb.delete();
        mon_rd = '0;
        mon_er = 1'b0;
        continue;
      end
      if (rsp_valid != '0) begin
        if (sb.size() == 0) begin
          chk("rsp_unexpected", 1'b0, 64'(rsp_valid), 64'd0);
        end else begin
          mon_e = sb.pop_front();
          mon_v = '0;
          mon_v[mon_e.owner] = 1'b1;
          chk("rsp_valid", rsp_valid == mon_v,
              64'(rsp_valid), 64'(mon_v));
          chk("rsp_rdata", rsp_rdata == mon_e.rdata,
              64'(rsp_rdata), 64'(mon_e.rdata));
          chk("rsp_err", rsp_err == mon_e.err,
              64'(rsp_err), 64'(mon_e.err));
          chk("rsp_cycle", cyc == mon_e.due,
              64'(cyc), 64'(mon_e.due));
          chk("resp_m_transfer", m_transfer == 2'b00,
              64'(m_transfer), 64'd0);
          mon_rd = mon_e.rdata;
          mon_er = mon_e.err;
        end
      end else begin
        chk("rsp_hold", rsp_rdata == mon_rd && rsp_err == mon_er,
            {31'd0, rsp_err, rsp_rdata},
            {31'd0, mon_er, mon_rd});
        if (sb.size() > 0 && cyc > sb[0].due) begin
          chk("rsp_missing", 1'b0, 64'(cyc), 64'(sb[0].due));
          void'(sb.pop_front());
        end else if (sb.size() > 0 && cyc > sb[0].acc) begin
          chk("m_transfer", m_transfer ==
              (sb[0].wr ? 2'b01 : 2'b10),
              64'(m_transfer), sb[0].wr ? 64'd1 : 64'd2);
          chk("m_address", m_address == sb[0].addr,
              64'(m_address), 64'(sb[0].addr));
          chk("m_write_data", m_write_data == sb[0].wdata,
              64'(m_write_data), 64'(sb[0].wdata));
        end else begin
          chk("m_transfer_idle", m_transfer == 2'b00,
              64'(m_transfer), 64'd0);
        end
      end
    end
  end

  // APB master/slave stand-in: setup at cycle 2, enable from 3.
  slv_t slv_cur;
  int   slv_k = 0;

  initial begin
    apb_penable = 1'b0;
    apb_pready  = 1'b0;
    apb_pslverr = 1'b0;
    apb_pparerr = 1'b0;
    apb_prdata  = '0;
    forever begin
      @(negedge PCLK);
      if (!PRESETn || m_transfer == 2'b00) begin
        if (!PRESETn) sq.delete();
        slv_k       = 0;
        apb_penable = 1'b0;
        apb_pready  = 1'b0;
        apb_pslverr = 1'b0;
        apb_pparerr = 1'b0;
        continue;
      end
      if (slv_k == 0) begin
        if (sq.size() == 0) begin
          chk("slave_cmd", 1'b0, 64'(m_transfer), 64'd0);
          slv_cur.w     = 0;
          slv_cur.rdata = '0;
          slv_cur.err   = 1'b0;
          slv_cur.par   = 1'b0;
        end else begin
          slv_cur = sq.pop_front();
        end
      end
      slv_k++;
      apb_penable = (slv_k >= 3);
      apb_pready  = (slv_k >= 3 + slv_cur.w);
      apb_pslverr = apb_pready && slv_cur.err && !slv_cur.par;
      apb_pparerr = apb_pready && slv_cur.err && slv_cur.par;
      apb_prdata  = apb_pready ? slv_cur.rdata : $urandom;
    end
  end

  initial begin
    PRESETn   = 1'b0;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    model_reset();
    repeat (2) @(negedge PCLK);
    chk("reset_state", outs_zero(),
        {32'(busy), 32'(grant_id)}, 64'd0);
    @(posedge PCLK);
    #1;
    PRESETn = 1'b1;

    // Single zero-wait read from requester 0.
    nx_w = 0; nx_rdata = 32'hCAFE_F00D;
    nx_err = 1'b0; nx_par = 1'b0;
    req_write[0] = 1'b0;
    req_addr[0 +: AW] = 32'h0000_1004;
    req_valid[0] = 1'b1;
    drain();

    // Contention from reset: both requesters held valid.
    new_req(0);
    new_req(1);
    do_reset(2);
    rnd_params = 1;
    rand_nx();
    hold_all = 1;
    wins.delete();
    run_until(4);
    hold_all = 0;
    req_valid = '0;
    for (int i = 0; i < 4; i++) begin
      if (i < wins.size())
        chk("contention_order", wins[i] == i % 2,
            64'(wins[i]), 64'(i % 2));
    end
    drain();

    // Write with five wait states.
    rnd_params = 0;
    nx_w = 5; nx_rdata = $urandom;
    nx_err = 1'b0; nx_par = 1'b0;
    new_req(0);
    req_write[0] = 1'b1;
    req_addr[0 +: AW] = 32'h0000_2000;
    drain();

    // Slave error, clean follow-up, parity error.
    nx_w = 1; nx_rdata = $urandom; nx_err = 1'b1;
    new_req(1);
    req_write[1] = 1'b0;
    drain();
    nx_rdata = $urandom; nx_err = 1'b0;
    new_req(1);
    req_write[1] = 1'b0;
    drain();
    nx_err = 1'b1; nx_par = 1'b1;
    new_req(0);
    drain();

    // Reset in the middle of an ACTIVE transfer.
    nx_w = 3; nx_err = 1'b0; nx_par = 1'b0;
    wins.delete();
    new_req(0);
    run_until(1);
    step();
    step();
    new_req(0);
    new_req(1);
    do_reset(2);
    wins.delete();
    run_until(1);
    if (wins.size() > 0)
      chk("first_after_reset", wins[0] == 0,
          64'(wins[0]), 64'd0);
    req_valid = '0;
    drain();

    // Randomized traffic with drops and random slave timing.
    rnd = 1;
    rnd_params = 1;
    rand_nx();
    repeat (600) step();
    rnd = 0;
    req_valid = '0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
